// File: rtl/mainfsm_pkg.sv
// mainfsm_pkg: shared types and constants for the multicycle ARM main FSM.
// State encoding, instruction-field encodings, datapath select constants,
// the control-word struct, and the state-to-control-word decode function.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype;

  // Instr[27:26] encodings
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Per-state control word; branch is internal and only feeds PCS.
  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       illegal;
  } ctrl_t;

  // Moore decode: every field not set for a state stays 0.
  function automatic ctrl_t ctrl_of(input statetype s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.nextpc    = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALU;
      end
      DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALU;
      end
      MEMADR: begin
        c.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        c.adrsrc = 1'b1;
      end
      MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regw      = 1'b1;
      end
      MEMWR: begin
        c.adrsrc = 1'b1;
        c.memw   = 1'b1;
      end
      EXECUTER: begin
        c.aluop = 1'b1;
      end
      EXECUTEI: begin
        c.alusrcb = SRCB_IMM;
        c.aluop   = 1'b1;
      end
      ALUWB: begin
        c.regw = 1'b1;
      end
      BRANCH: begin
        c.alusrcb   = SRCB_IMM;
        c.resultsrc = RES_ALU;
        c.branch    = 1'b1;
      end
      UNKNOWN: begin
        c.illegal = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mainfsm_if.sv
// mainfsm_if: instruction-field inputs and control outputs of the main FSM.
// master = decoder/datapath side, slave = the FSM itself.
interface mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCS;
  logic       Illegal;

  modport master (
    output Op, Funct, Rd,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, PCS, Illegal
  );

  modport slave (
    input  Op, Funct, Rd,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, PCS, Illegal
  );
endinterface

// File: rtl/mainfsm_outdec.sv
// mainfsm_outdec: combinational state -> control word decode.
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  statetype state,
  output ctrl_t    ctrl
);

  // Translate a state into its full control word.
  always_comb begin
    ctrl = ctrl_of(state);
  end

endmodule

// File: rtl/mainfsm.sv
// mainfsm: multicycle ARM main control FSM.
// Holds the state register, next-state logic and PCS. The control word is
// decoded from the next state and registered alongside it, so every output
// except PCS comes straight from flops and matches the current state.
// Optional build macro: MAINFSM_UNKNOWN_TRAP_EN makes UNKNOWN absorbing until
// reset; otherwise UNKNOWN lasts one cycle and returns to FETCH.
module mainfsm
  import mainfsm_pkg::*;
(
  input logic       clk,
  input logic       reset,
  mainfsm_if.slave  bus
);

  statetype state_r;
  statetype state_next_s;
  ctrl_t    ctrl_r;
  ctrl_t    ctrl_next_s;
  logic     funct_unused_s;

  // Only I (bit 5) and L/S (bit 0) steer the sequence.
  assign funct_unused_s = ^bus.Funct[4:1];

  // Next-state selection from the current state and instruction fields.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH:    state_next_s = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_MEM: state_next_s = MEMADR;
          OP_BR:  state_next_s = BRANCH;
          OP_DP: begin
            if (bus.Funct[5]) begin
              state_next_s = EXECUTEI;
            end else begin
              state_next_s = EXECUTER;
            end
          end
          default: state_next_s = UNKNOWN;
        endcase
      end
      MEMADR: begin
        if (bus.Funct[0]) begin
          state_next_s = MEMRD;
        end else begin
          state_next_s = MEMWR;
        end
      end
      MEMRD:    state_next_s = MEMWB;
      MEMWB:    state_next_s = FETCH;
      MEMWR:    state_next_s = FETCH;
      EXECUTER: state_next_s = ALUWB;
      EXECUTEI: state_next_s = ALUWB;
      ALUWB:    state_next_s = FETCH;
      BRANCH:   state_next_s = FETCH;
`ifdef MAINFSM_UNKNOWN_TRAP_EN
      UNKNOWN:  state_next_s = UNKNOWN;
`else
      UNKNOWN:  state_next_s = FETCH;
`endif
      default:  state_next_s = FETCH;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state (state_next_s),
    .ctrl  (ctrl_next_s)
  );

  // State and control-word registers; reset parks both in FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
      ctrl_r  <= ctrl_of(FETCH);
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= ctrl_next_s;
    end
  end

  assign bus.IRWrite   = ctrl_r.irwrite;
  assign bus.AdrSrc    = ctrl_r.adrsrc;
  assign bus.ALUSrcA   = ctrl_r.alusrca;
  assign bus.ALUSrcB   = ctrl_r.alusrcb;
  assign bus.ResultSrc = ctrl_r.resultsrc;
  assign bus.ALUOp     = ctrl_r.aluop;
  assign bus.NextPC    = ctrl_r.nextpc;
  assign bus.RegW      = ctrl_r.regw;
  assign bus.MemW      = ctrl_r.memw;
  assign bus.Illegal   = ctrl_r.illegal;
  // Writeback to R15 redirects the PC, as does a branch.
  assign bus.PCS       = ctrl_r.branch | (ctrl_r.regw & (bus.Rd == 4'hF));

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: directed bench for the multicycle main FSM.
// Output vector order: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc ALUOp NextPC
// RegW MemW PCS Illegal (13 bits).
module tb_mainfsm;
  import mainfsm_pkg::*;

  localparam logic [12:0] O_FETCH  = 13'b1_0_1_10_10_0_1_0_0_0_0;
  localparam logic [12:0] O_DECODE = 13'b0_0_1_10_10_0_0_0_0_0_0;
  localparam logic [12:0] O_MEMADR = 13'b0_0_0_01_00_0_0_0_0_0_0;
  localparam logic [12:0] O_MEMRD  = 13'b0_1_0_00_00_0_0_0_0_0_0;
  localparam logic [12:0] O_MEMWB  = 13'b0_0_0_00_01_0_0_1_0_0_0;
  localparam logic [12:0] O_MEMWBP = 13'b0_0_0_00_01_0_0_1_0_1_0;
  localparam logic [12:0] O_MEMWR  = 13'b0_1_0_00_00_0_0_0_1_0_0;
  localparam logic [12:0] O_EXECR  = 13'b0_0_0_00_00_1_0_0_0_0_0;
  localparam logic [12:0] O_EXECI  = 13'b0_0_0_01_00_1_0_0_0_0_0;
  localparam logic [12:0] O_ALUWB  = 13'b0_0_0_00_00_0_0_1_0_0_0;
  localparam logic [12:0] O_ALUWBP = 13'b0_0_0_00_00_0_0_1_0_1_0;
  localparam logic [12:0] O_BRANCH = 13'b0_0_0_01_10_0_0_0_0_1_0;
  localparam logic [12:0] O_UNK    = 13'b0_0_0_00_00_0_0_0_0_0_1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mainfsm_if bus ();

  mainfsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] outs();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ALUOp, bus.NextPC, bus.RegW, bus.MemW, bus.PCS, bus.Illegal};
  endfunction

  task automatic check(input string tag, input statetype es, input logic [12:0] eo);
    checks++;
    assert (dut.state_r === es) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, dut.state_r, es);
    end
    checks++;
    assert (outs() === eo) else begin
      errors++;
      $error("FAIL %s outputs: got %b expected %b", tag, outs(), eo);
    end
  endtask

  task automatic step(input string tag, input statetype es, input logic [12:0] eo);
    @(negedge clk);
    check(tag, es, eo);
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    bus.Op    = op;
    bus.Funct = f;
    bus.Rd    = rd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    set_instr(2'b00, 6'b000000, 4'd3);
    repeat (3) @(negedge clk);
    check("reset_hold", FETCH, O_FETCH);
    reset = 1'b1;

    // ADD register, Rd=3
    step("add_decode", DECODE,   O_DECODE);
    step("add_exec",   EXECUTER, O_EXECR);
    step("add_wb",     ALUWB,    O_ALUWB);
    step("add_fetch",  FETCH,    O_FETCH);

    // LDR, Rd=2
    set_instr(2'b01, 6'b011001, 4'd2);
    step("ldr_decode", DECODE, O_DECODE);
    step("ldr_adr",    MEMADR, O_MEMADR);
    step("ldr_rd",     MEMRD,  O_MEMRD);
    step("ldr_wb",     MEMWB,  O_MEMWB);
    step("ldr_fetch",  FETCH,  O_FETCH);

    // STR
    set_instr(2'b01, 6'b011000, 4'd2);
    step("str_decode", DECODE, O_DECODE);
    step("str_adr",    MEMADR, O_MEMADR);
    step("str_wr",     MEMWR,  O_MEMWR);
    step("str_fetch",  FETCH,  O_FETCH);

    // B
    set_instr(2'b10, 6'b000000, 4'd0);
    step("b_decode", DECODE, O_DECODE);
    step("b_branch", BRANCH, O_BRANCH);
    step("b_fetch",  FETCH,  O_FETCH);

    // ADD immediate to R15
    set_instr(2'b00, 6'b100000, 4'hF);
    step("addi_decode", DECODE,   O_DECODE);
    step("addi_exec",   EXECUTEI, O_EXECI);
    step("addi_wb",     ALUWB,    O_ALUWBP);
    step("addi_fetch",  FETCH,    O_FETCH);

    // LDR to R15
    set_instr(2'b01, 6'b011001, 4'hF);
    step("ldrpc_decode", DECODE, O_DECODE);
    step("ldrpc_adr",    MEMADR, O_MEMADR);
    step("ldrpc_rd",     MEMRD,  O_MEMRD);
    step("ldrpc_wb",     MEMWB,  O_MEMWBP);
    step("ldrpc_fetch",  FETCH,  O_FETCH);

    // Undefined op
    set_instr(2'b11, 6'b000000, 4'd1);
    step("und_decode", DECODE,  O_DECODE);
    step("und_state",  UNKNOWN, O_UNK);
`ifdef MAINFSM_UNKNOWN_TRAP_EN
    set_instr(2'b00, 6'b000000, 4'd3);
    for (int i = 0; i < 10; i++) begin
      step("und_trap", UNKNOWN, O_UNK);
    end
    #2 reset = 1'b0;
    #1 check("und_reset", FETCH, O_FETCH);
    @(negedge clk);
    reset = 1'b1;
`else
    set_instr(2'b00, 6'b000000, 4'd3);
    step("und_skip", FETCH, O_FETCH);
`endif

    // Asynchronous reset in the middle of MEMRD
    set_instr(2'b01, 6'b011001, 4'd2);
    step("ar_decode", DECODE, O_DECODE);
    step("ar_adr",    MEMADR, O_MEMADR);
    step("ar_rd",     MEMRD,  O_MEMRD);
    #2 reset = 1'b0;
    #1 check("ar_async", FETCH, O_FETCH);
    step("ar_held", FETCH, O_FETCH);
    reset = 1'b1;
    step("ar2_decode", DECODE, O_DECODE);
    step("ar2_adr",    MEMADR, O_MEMADR);
    step("ar2_rd",     MEMRD,  O_MEMRD);
    step("ar2_wb",     MEMWB,  O_MEMWB);
    step("ar2_fetch",  FETCH,  O_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
